// File: rtl/trdb_trigger_unit_if.sv
// Configuration bus for trdb_trigger_unit: register write/read port.
// The master drives strobes, address and write data; the slave returns
// registered read data qualified by cfg_rvalid.
interface trdb_trigger_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            cfg_we;
    logic            cfg_re;
    logic [1:0]      cfg_addr;
    logic [XLEN-1:0] cfg_wdata;
    logic [XLEN-1:0] cfg_rdata;
    logic            cfg_rvalid;

    modport master (
        output cfg_we, cfg_re, cfg_addr, cfg_wdata,
        input  cfg_rdata, cfg_rvalid
    );

    modport slave (
        input  cfg_we, cfg_re, cfg_addr, cfg_wdata,
        output cfg_rdata, cfg_rvalid
    );
endinterface

// File: rtl/trdb_trigger_unit.sv
// Trace trigger unit: watches the retired-instruction stream and emits
// one-cycle trace_req_on_o / trace_req_off_o pulses when the programmed
// start/stop addresses retire. Optional address-range mode is compiled in
// with the TRDB_TRIGGER_RANGE_EN macro (default build: exact-address only).
module trdb_trigger_unit #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned SKIP_W = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    trdb_trigger_unit_if.slave  cfg,
    input  logic                iretire_i,
    input  logic [XLEN-1:0]     iaddr_i,
    output logic                trace_req_on_o,
    output logic                trace_req_off_o,
    output logic [1:0]          state_o
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_TRACING = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    logic              ctrl_en;
    logic              ctrl_oneshot;
    logic              ctrl_range;
    logic [XLEN-1:0]   start_addr;
    logic [XLEN-1:0]   stop_addr;
    logic [SKIP_W-1:0] skip;

    logic [1:0]        state_q, state_d;
    logic [SKIP_W-1:0] cnt_q, cnt_d;
    logic              on_d, off_d;

    logic              start_hit, stop_hit, skip_wr;
    logic              arm_fire, arm_count, trc_stop;

    assign start_hit = iretire_i && (iaddr_i == start_addr);
    assign stop_hit  = iretire_i && (iaddr_i == stop_addr);
    assign skip_wr   = cfg.cfg_we && (cfg.cfg_addr == 2'd3);

`ifdef TRDB_TRIGGER_RANGE_EN
    logic in_range;
    assign in_range = (iaddr_i >= start_addr) && (iaddr_i <= stop_addr);
`else
    assign ctrl_range = 1'b0;
`endif

    // Configuration registers; new values are seen by the FSM from the next cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ctrl_en      <= 1'b0;
            ctrl_oneshot <= 1'b0;
`ifdef TRDB_TRIGGER_RANGE_EN
            ctrl_range   <= 1'b0;
`endif
            start_addr   <= '0;
            stop_addr    <= '0;
            skip         <= '0;
        end else if (cfg.cfg_we) begin
            case (cfg.cfg_addr)
                2'd0: begin
                    ctrl_en      <= cfg.cfg_wdata[0];
                    ctrl_oneshot <= cfg.cfg_wdata[1];
`ifdef TRDB_TRIGGER_RANGE_EN
                    ctrl_range   <= cfg.cfg_wdata[2];
`endif
                end
                2'd1:    start_addr <= cfg.cfg_wdata;
                2'd2:    stop_addr  <= cfg.cfg_wdata;
                default: skip       <= cfg.cfg_wdata[SKIP_W-1:0];
            endcase
        end
    end

    // Registered read response; a write in the same cycle suppresses the read.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cfg.cfg_rvalid <= 1'b0;
            cfg.cfg_rdata  <= '0;
        end else begin
            cfg.cfg_rvalid <= cfg.cfg_re && !cfg.cfg_we;
            if (cfg.cfg_re && !cfg.cfg_we) begin
                case (cfg.cfg_addr)
                    2'd0:    cfg.cfg_rdata <= {{(XLEN-3){1'b0}}, ctrl_range, ctrl_oneshot, ctrl_en};
                    2'd1:    cfg.cfg_rdata <= start_addr;
                    2'd2:    cfg.cfg_rdata <= stop_addr;
                    default: cfg.cfg_rdata <= XLEN'(skip);
                endcase
            end
        end
    end

    // Trigger FSM next-state logic; pulses are registered so a hit in cycle N shows in N+1.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        on_d      = 1'b0;
        off_d     = 1'b0;
        arm_fire  = start_hit && (cnt_q == skip);
        arm_count = start_hit && (cnt_q != skip);
        trc_stop  = stop_hit;
`ifdef TRDB_TRIGGER_RANGE_EN
        if (ctrl_range) begin
            arm_fire  = iretire_i && in_range;
            arm_count = 1'b0;
            trc_stop  = iretire_i && !in_range;
        end
`endif
        case (state_q)
            ST_IDLE: begin
                if (ctrl_en) begin
                    state_d = ST_ARMED;
                    cnt_d   = '0;
                end
            end
            ST_ARMED: begin
                if (!ctrl_en) begin
                    state_d = ST_IDLE;
                end else if (arm_fire) begin
                    state_d = ST_TRACING;
                    on_d    = 1'b1;
                end else if (arm_count) begin
                    cnt_d = cnt_q + SKIP_W'(1);
                end
            end
            ST_TRACING: begin
                // Disable dominates a simultaneous stop hit; either way one off pulse.
                if (!ctrl_en) begin
                    state_d = ST_IDLE;
                    off_d   = 1'b1;
                end else if (trc_stop) begin
                    off_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ctrl_oneshot ? ST_DONE : ST_ARMED;
                end
            end
            default: begin
                if (!ctrl_en) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
        if (skip_wr && (state_q == ST_ARMED)) begin
            cnt_d = '0;
        end
    end

    // FSM state, skip counter and request pulse registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            trace_req_on_o  <= 1'b0;
            trace_req_off_o <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            trace_req_on_o  <= on_d;
            trace_req_off_o <= off_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_trdb_trigger_unit.sv
// Directed self-checking bench for trdb_trigger_unit.
module tb_trdb_trigger_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        iretire_i = 1'b0;
    logic [31:0] iaddr_i = '0;
    logic        trace_req_on_o;
    logic        trace_req_off_o;
    logic [1:0]  state_o;

    int tests = 0;
    int fails = 0;

    trdb_trigger_unit_if #(.XLEN(32)) cfg_bus ();

    trdb_trigger_unit #(.XLEN(32), .SKIP_W(8)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .cfg             (cfg_bus.slave),
        .iretire_i       (iretire_i),
        .iaddr_i         (iaddr_i),
        .trace_req_on_o  (trace_req_on_o),
        .trace_req_off_o (trace_req_off_o),
        .state_o         (state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Check the three trigger outputs together.
    task automatic chk_out(input string tag, input logic on, input logic off, input logic [1:0] st);
        chk({tag, ".on"}, 32'(trace_req_on_o), 32'(on));
        chk({tag, ".off"}, 32'(trace_req_off_o), 32'(off));
        chk({tag, ".state"}, 32'(state_o), 32'(st));
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [31:0] data);
        cfg_bus.cfg_we    = 1'b1;
        cfg_bus.cfg_addr  = addr;
        cfg_bus.cfg_wdata = data;
        step();
        cfg_bus.cfg_we    = 1'b0;
    endtask

    task automatic cfg_read(input string tag, input logic [1:0] addr, input logic [31:0] exp);
        cfg_bus.cfg_re   = 1'b1;
        cfg_bus.cfg_addr = addr;
        step();
        cfg_bus.cfg_re   = 1'b0;
        chk({tag, ".rvalid"}, 32'(cfg_bus.cfg_rvalid), 32'd1);
        chk({tag, ".rdata"}, cfg_bus.cfg_rdata, exp);
    endtask

    task automatic retire(input logic [31:0] addr);
        iretire_i = 1'b1;
        iaddr_i   = addr;
        step();
        iretire_i = 1'b0;
    endtask

    initial begin
        cfg_bus.cfg_we    = 1'b0;
        cfg_bus.cfg_re    = 1'b0;
        cfg_bus.cfg_addr  = '0;
        cfg_bus.cfg_wdata = '0;

        // Reset state
        step(); step(); step();
        chk_out("reset", 1'b0, 1'b0, 2'd0);
        chk("reset.rvalid", 32'(cfg_bus.cfg_rvalid), 32'd0);
        rst_ni = 1'b1;
        cfg_read("rd_ctrl_reset", 2'd0, 32'h0);

        // Basic start/stop
        cfg_write(2'd1, 32'h100);
        cfg_write(2'd2, 32'h200);
        cfg_write(2'd0, 32'h1);
        chk("en_latency.state", 32'(state_o), 32'd0);
        step();
        chk("armed.state", 32'(state_o), 32'd1);
        retire(32'h100);
        chk_out("start", 1'b1, 1'b0, 2'd2);
        step();
        chk_out("start_pulse_end", 1'b0, 1'b0, 2'd2);
        retire(32'h200);
        chk_out("stop", 1'b0, 1'b1, 2'd1);
        step();
        chk_out("stop_pulse_end", 1'b0, 1'b0, 2'd1);
        cfg_read("rd_start", 2'd1, 32'h100);

        // Write and hit in the same cycle: old START still matches
        cfg_bus.cfg_we    = 1'b1;
        cfg_bus.cfg_addr  = 2'd1;
        cfg_bus.cfg_wdata = 32'h500;
        iretire_i = 1'b1;
        iaddr_i   = 32'h100;
        step();
        cfg_bus.cfg_we = 1'b0;
        iretire_i      = 1'b0;
        chk_out("old_regs", 1'b1, 1'b0, 2'd2);
        retire(32'h200);
        chk_out("old_regs_stop", 1'b0, 1'b1, 2'd1);
        cfg_write(2'd1, 32'h100);

        // Read suppressed by a same-cycle write
        cfg_bus.cfg_re = 1'b1;
        cfg_write(2'd2, 32'h200);
        cfg_bus.cfg_re = 1'b0;
        chk("rd_with_wr.rvalid", 32'(cfg_bus.cfg_rvalid), 32'd0);

        // SKIP width truncation, then SKIP=2
        cfg_write(2'd3, 32'h1FF);
        cfg_read("rd_skip", 2'd3, 32'hFF);
        cfg_write(2'd3, 32'h2);
        retire(32'h100);
        chk_out("skip1", 1'b0, 1'b0, 2'd1);
        retire(32'h100);
        chk_out("skip2", 1'b0, 1'b0, 2'd1);
        retire(32'h100);
        chk_out("skip3", 1'b1, 1'b0, 2'd2);
        retire(32'h200);
        chk_out("skip_stop", 1'b0, 1'b1, 2'd1);
        cfg_write(2'd3, 32'h0);

        // ONESHOT
        cfg_write(2'd0, 32'h3);
        retire(32'h100);
        chk_out("os_start", 1'b1, 1'b0, 2'd2);
        retire(32'h200);
        chk_out("os_stop", 1'b0, 1'b1, 2'd3);
        retire(32'h100);
        chk_out("os_done_hold", 1'b0, 1'b0, 2'd3);
        cfg_write(2'd0, 32'h0);
        step();
        chk_out("os_idle", 1'b0, 1'b0, 2'd0);

        // START == STOP
        cfg_write(2'd1, 32'h300);
        cfg_write(2'd2, 32'h300);
        cfg_write(2'd0, 32'h1);
        step();
        retire(32'h300);
        chk_out("same_first", 1'b1, 1'b0, 2'd2);
        retire(32'h300);
        chk_out("same_second", 1'b0, 1'b1, 2'd1);

        // EN cleared while TRACING
        retire(32'h300);
        chk_out("dis_tracing", 1'b1, 1'b0, 2'd2);
        cfg_write(2'd0, 32'h0);
        chk_out("dis_written", 1'b0, 1'b0, 2'd2);
        step();
        chk_out("dis_off", 1'b0, 1'b1, 2'd0);
        step();
        chk_out("dis_after", 1'b0, 1'b0, 2'd0);
        cfg_read("rd_ctrl_dis", 2'd0, 32'h0);

        // Reset mid-TRACING
        cfg_write(2'd0, 32'h1);
        step();
        retire(32'h300);
        chk_out("pre_rst", 1'b1, 1'b0, 2'd2);
        rst_ni = 1'b0;
        step();
        chk_out("mid_rst", 1'b0, 1'b0, 2'd0);
        rst_ni = 1'b1;
        cfg_read("rd_start_rst", 2'd1, 32'h0);

`ifdef TRDB_TRIGGER_RANGE_EN
        cfg_write(2'd1, 32'h1000);
        cfg_write(2'd2, 32'h1FFF);
        cfg_write(2'd0, 32'h5);
        cfg_read("rd_ctrl_range", 2'd0, 32'h5);
        retire(32'h0FFC);
        chk_out("rng_below", 1'b0, 1'b0, 2'd1);
        retire(32'h1000);
        chk_out("rng_on", 1'b1, 1'b0, 2'd2);
        retire(32'h1FFC);
        chk_out("rng_inside", 1'b0, 1'b0, 2'd2);
        retire(32'h2000);
        chk_out("rng_off", 1'b0, 1'b1, 2'd1);
`else
        cfg_write(2'd0, 32'h4);
        cfg_read("rd_ctrl_norange", 2'd0, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
